// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: FSM state encoding,
// operation codes, exception codes and the WAIT-cycle counter width.
package muldiv_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StWait   = 3'd2,
    StCommit = 3'd3,
    StExc    = 3'd4
  } state_e;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;

  typedef enum logic [1:0] {
    ExcNone    = 2'b00,
    ExcDiv0    = 2'b01,
    ExcTimeout = 2'b10,
    ExcIllegal = 2'b11
  } exc_code_e;

  localparam int unsigned CycW = 6;
  localparam logic [CycW-1:0] CycMax = 6'd63;

  function automatic logic op_is_legal(logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/wait_timer.sv
// WAIT-cycle counter for the muldiv sequencer.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : synchronous clear to 0 (wins over en_i)
//   en_i          : increment by one, saturating at 63
//   count_o       : current count
//   tc_o          : terminal count, high while count_o == TIMEOUT-1
module wait_timer
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [CycW-1:0] count_o,
  output logic            tc_o
);

  localparam logic [CycW-1:0] TcVal = CycW'(TIMEOUT - 1);

  logic [CycW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != CycMax)) begin
      count_d = count_q + CycW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = (count_q == TcVal);

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequencer that launches a Mult or Div unit operation, waits for its
// completion (with timeout), and commits the result to HI/LO or raises an
// exception.
//   clk_i, rst_ni           : clock, asynchronous active-low reset
//   req_i, op_i             : request and op code (00 mult, 01 div), sampled in IDLE
//   abort_i                 : flush any in-flight operation
//   mult_done_i, div_done_i : unit completion flags
//   div0_i                  : divide-by-zero flag, qualified by div_done_i
//   mult_start_o/div_start_o: one-cycle unit start pulses
//   hi_sel_o, lo_sel_o      : HI/LO source select (1 = Mult, 0 = Div)
//   write_hi_o, write_lo_o  : HI/LO write enables
//   busy_o, done_o, exc_o   : status, commit pulse, exception pulse
//   exc_code_o              : exception cause while exc_o is high
//   cycles_o                : WAIT-cycle count of the current or last operation
// All outputs decode registered state only; no input reaches an output
// combinationally.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned TIMEOUT = 40
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_i,
  input  logic [1:0]      op_i,
  input  logic            abort_i,
  input  logic            mult_done_i,
  input  logic            div_done_i,
  input  logic            div0_i,
  output logic            mult_start_o,
  output logic            div_start_o,
  output logic            hi_sel_o,
  output logic            lo_sel_o,
  output logic            write_hi_o,
  output logic            write_lo_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            exc_o,
  output logic [1:0]      exc_code_o,
  output logic [CycW-1:0] cycles_o
);

  state_e    state_q, state_d;
  logic [1:0] op_q, op_d;
  exc_code_e exc_code_q, exc_code_d;

  logic tc;
  logic unit_done;

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (state_q == StStart),
    .en_i   (state_q == StWait),
    .count_o(cycles_o),
    .tc_o   (tc)
  );

  // Only the selected unit's done flag counts.
  assign unit_done = (op_q == OP_MULT) ? mult_done_i : div_done_i;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    exc_code_d = exc_code_q;
    if (abort_i && (state_q != StIdle)) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_i) begin
            if (op_is_legal(op_i)) begin
              op_d    = op_i;
              state_d = StStart;
            end else begin
              exc_code_d = ExcIllegal;
              state_d    = StExc;
            end
          end
        end
        StStart: state_d = StWait;
        StWait: begin
          // A done flag on the terminal-count cycle beats the timeout.
          if (unit_done) begin
            if ((op_q == OP_DIV) && div0_i) begin
              exc_code_d = ExcDiv0;
              state_d    = StExc;
            end else begin
              state_d = StCommit;
            end
          end else if (tc) begin
            exc_code_d = ExcTimeout;
            state_d    = StExc;
          end
        end
        StCommit: state_d = StIdle;
        StExc:    state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      op_q       <= OP_MULT;
      exc_code_q <= ExcNone;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      exc_code_q <= exc_code_d;
    end
  end

  logic op_active;

  always_comb begin
    op_active    = (state_q == StStart) || (state_q == StWait) || (state_q == StCommit);
    busy_o       = (state_q != StIdle);
    mult_start_o = (state_q == StStart) && (op_q == OP_MULT);
    div_start_o  = (state_q == StStart) && (op_q == OP_DIV);
    hi_sel_o     = op_active && (op_q == OP_MULT);
    lo_sel_o     = op_active && (op_q == OP_MULT);
    write_hi_o   = (state_q == StCommit);
    write_lo_o   = (state_q == StCommit);
    done_o       = (state_q == StCommit);
    exc_o        = (state_q == StExc);
    exc_code_o   = (state_q == StExc) ? exc_code_q : ExcNone;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 40, maximum WAIT cycles before a timeout exception; legal range 2..63.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-004 req  input  1  operation request from the main control FSM; sampled only in IDLE.
REQ-005 op  input  2  00 = mult, 01 = div, 10/11 = illegal; sampled with req.
REQ-006 abort  input  1  flush any in-flight operation.
REQ-007 mult_done, div_done, div0  input  1 each  completion and divide-by-zero flags from the Mult and Div units.
REQ-008 mult_start, div_start  output  1 each  one-cycle start pulses to the units.
REQ-009 hi_sel, lo_sel  output  1 each  HI/LO source mux selects: 0 = Div, 1 = Mult.
REQ-010 write_hi, write_lo  output  1 each  HI/LO register write enables.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on successful commit.
REQ-013 exc  output  1  one-cycle exception pulse.
REQ-014 exc_code  output  2  01 = div0, 10 = timeout, 11 = illegal op; valid while exc = 1, otherwise 00.
REQ-015 cycles  output  6  WAIT-cycle count of the current or last operation.

Function
REQ-016 The FSM SHALL have the states IDLE, START, WAIT, COMMIT and EXC.
REQ-017 In IDLE, req = 1 with a legal op SHALL latch op and move to START; req = 1 with an illegal op SHALL move to EXC with code 11; req = 0 SHALL remain in IDLE.
REQ-018 START SHALL assert mult_start or div_start for exactly one cycle, according to the latched op, clear cycles to 0, and move to WAIT.
REQ-019 Each cycle in WAIT SHALL increment cycles by 1, saturating at 63.
REQ-020 In WAIT, the done flag of the selected unit SHALL cause a move to COMMIT; for div with div0 = 1 in the same cycle, the move SHALL be to EXC with code 01 instead.
REQ-021 The done flag of the unselected unit SHALL be ignored.
REQ-022 In WAIT, reaching cycles = TIMEOUT-1 without a done flag SHALL cause a move to EXC with code 10; a done flag in that same cycle SHALL take priority over the timeout.
REQ-023 COMMIT SHALL assert write_hi, write_lo and done for exactly one cycle, with hi_sel = lo_sel = 1 for mult and 0 for div, and then move to IDLE.
REQ-024 hi_sel and lo_sel SHALL hold the latched-op value from START through COMMIT, and SHALL be 0 in IDLE.
REQ-025 EXC SHALL assert exc with exc_code for one cycle, SHALL NOT write HI or LO, and SHALL move to IDLE.
REQ-026 Latency from req sampled in IDLE to the done pulse SHALL be N + 3 cycles, where N is the number of WAIT cycles up to and including the one in which the unit's done flag is seen.
REQ-027 req while busy = 1 SHALL be ignored; requests are not queued.
REQ-028 abort = 1 in any non-IDLE state SHALL force IDLE on the next edge, with no write, done or exc pulse on that edge.
REQ-029 abort SHALL take priority over all other transitions in the same cycle; abort in IDLE SHALL have no effect.
REQ-030 A new req SHALL be accepted on the first cycle back in IDLE after COMMIT, EXC or abort.

Reset
REQ-031 reset = 0 SHALL immediately force IDLE.
REQ-032 reset = 0 SHALL force every output to 0: starts, selects, writes, busy, done, exc, exc_code and cycles.
REQ-033 reset asserted mid-operation SHALL discard the latched op and SHALL NOT produce any write, done or exc pulse.

Structure
REQ-034 The state encoding, op codes (OP_MULT, OP_DIV) and exception codes SHALL reside in a shared muldiv_pkg package.
REQ-035 The WAIT counter SHALL be one sub-module, wait_timer, with clear, enable, saturate-at-63 and a terminal-count output compared against TIMEOUT-1.
REQ-036 All outputs SHALL be driven from state registers or from the state decode only, with no combinational path from inputs to outputs.

Verification
REQ-037 Mult: op = 00 req, mult_done after 33 WAIT cycles -> one mult_start pulse; write_hi = write_lo = 1 with hi_sel = lo_sel = 1 and done = 1 in the same cycle; cycles = 33.
REQ-038 Div by zero: op = 01, div_done = div0 = 1 on the 3rd WAIT cycle -> exc = 1, exc_code = 01, no HI/LO write.
REQ-039 Timeout: TIMEOUT = 40, op = 01, div_done never asserted -> exc_code = 10 exactly 40 WAIT cycles after START; done arriving on that 40th cycle -> COMMIT instead.
REQ-040 Illegal op: op = 11 req -> exc_code = 11 two cycles after req; no start pulse.
REQ-041 Abort and reset: abort in WAIT -> IDLE next cycle with no pulses; reset = 0 in COMMIT -> all outputs 0 immediately.
REQ-042 Back-to-back: req held high across COMMIT -> second operation accepted the cycle after COMMIT; mult_done pulsed during a div ignored.
